// File: rtl/barrier_damage_gen_pkg.sv
// Shared constants and types for the barrier damage writer, barrier store and VGA sync.
package barrier_damage_gen_pkg;

  localparam int unsigned COORD_W     = 11;
  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned BARR_YSTART = 340;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_EMIT = 2'd2
  } shot_state_t;

endpackage

// File: rtl/barrier_damage_gen_pix_delay.sv
// Shift register that lines the raster coordinates up with the barrier pixel flag.
module pix_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 22
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/barrier_damage_gen.sv
// Player shot owner: flies the shot, finds the first barrier pixel it overlaps, emits damage.
module barrier_damage_gen
  import barrier_damage_gen_pkg::*;
#(
  parameter int unsigned BARR_YSTART = barrier_damage_gen_pkg::BARR_YSTART,
  parameter int unsigned SHOT_YSTART = 440,
  parameter int unsigned SHOT_YMIN   = 8,
  parameter int unsigned SHOT_SPEED  = 4,
  parameter int unsigned SHOT_LEN    = 8,
  parameter int unsigned PIX_LAT     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic               fire,
  input  logic [COORD_W-1:0] fire_x,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] xCoord,
  input  logic [COORD_W-1:0] yCoord,
  input  logic               is_barrier,
  output logic [COORD_W-1:0] damage_x,
  output logic [COORD_W-1:0] damage_y,
  output logic               new_damage,
  output logic               shot_active,
  output logic [COORD_W-1:0] shot_x,
  output logic [COORD_W-1:0] shot_y
);

  shot_state_t r_state, w_next;

  logic               w_rst;
  logic [COORD_W-1:0] w_xd, w_yd;
  logic               w_hit, w_have_hit, w_retire;
  logic [COORD_W-1:0] w_first_x, w_first_y;

  logic               r_hit_pending;
  logic [COORD_W-1:0] r_hit_x, r_hit_y;
  logic [COORD_W-1:0] r_damage_x, r_damage_y;
  logic               r_new_damage, r_shot_active;
  logic [COORD_W-1:0] r_shot_x, r_shot_y;

  assign w_rst = rst | restart;

  pix_delay #(
    .DEPTH (PIX_LAT),
    .W     (2 * COORD_W)
  ) u_pix_delay (
    .clk   (clk),
    .i_rst (w_rst),
    .i_d   ({xCoord, yCoord}),
    .o_q   ({w_xd, w_yd})
  );

  always_comb begin
    w_hit      = (r_state == ST_FLY) && is_barrier && (w_xd == r_shot_x) &&
                 (w_yd >= r_shot_y) && (w_yd <= r_shot_y + COORD_W'(SHOT_LEN - 1));
    w_have_hit = r_hit_pending | w_hit;
    w_retire   = r_shot_y < COORD_W'(SHOT_YMIN + SHOT_SPEED);
    // A hit arriving with the closing frame_tick is reported directly, bypassing the latch.
    w_first_x  = r_hit_pending ? r_hit_x : w_xd;
    w_first_y  = r_hit_pending ? r_hit_y : w_yd;
  end

  always_ff @(posedge clk) begin
    if (w_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (fire) w_next = ST_FLY;
      ST_FLY: begin
        if (frame_tick) begin
          if (w_have_hit)    w_next = ST_EMIT;
          else if (w_retire) w_next = ST_IDLE;
        end
      end
      ST_EMIT: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_hit_pending <= 1'b0;
      r_hit_x       <= '0;
      r_hit_y       <= '0;
      r_damage_x    <= '0;
      r_damage_y    <= '0;
      r_new_damage  <= 1'b0;
      r_shot_active <= 1'b0;
      r_shot_x      <= '0;
      r_shot_y      <= '0;
    end else begin
      r_new_damage <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (fire) begin
            r_shot_x      <= fire_x;
            r_shot_y      <= COORD_W'(SHOT_YSTART);
            r_hit_pending <= 1'b0;
            r_shot_active <= 1'b1;
          end
        end
        ST_FLY: begin
          if (w_hit && !r_hit_pending) begin
            r_hit_pending <= 1'b1;
            r_hit_x       <= w_xd;
            r_hit_y       <= w_yd;
          end
          if (frame_tick) begin
            if (w_have_hit) begin
              r_new_damage <= 1'b1;
              r_damage_x   <= w_first_x;
              r_damage_y   <= w_first_y - COORD_W'(BARR_YSTART);
            end else if (w_retire) begin
              r_shot_active <= 1'b0;
            end else begin
              r_shot_y <= r_shot_y - COORD_W'(SHOT_SPEED);
            end
          end
        end
        ST_EMIT: begin
          r_shot_active <= 1'b0;
          r_hit_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign damage_x    = r_damage_x;
  assign damage_y    = r_damage_y;
  assign new_damage  = r_new_damage;
  assign shot_active = r_shot_active;
  assign shot_x      = r_shot_x;
  assign shot_y      = r_shot_y;

endmodule

// File: tb/tb_barrier_damage_gen.sv
// Directed bench for barrier_damage_gen with a damage scoreboard.
module tb_barrier_damage_gen;

  logic        clk = 1'b0;
  logic        rst, restart, fire, frame_tick, is_barrier;
  logic [10:0] fire_x, xCoord, yCoord;
  logic [10:0] damage_x, damage_y, shot_x, shot_y;
  logic        new_damage, shot_active;

  int n_vec = 0;
  int n_err = 0;

  logic [21:0] sb_q [$];

  always #5 clk = ~clk;

  barrier_damage_gen dut (
    .clk         (clk),
    .rst         (rst),
    .restart     (restart),
    .fire        (fire),
    .fire_x      (fire_x),
    .frame_tick  (frame_tick),
    .xCoord      (xCoord),
    .yCoord      (yCoord),
    .is_barrier  (is_barrier),
    .damage_x    (damage_x),
    .damage_y    (damage_y),
    .new_damage  (new_damage),
    .shot_active (shot_active),
    .shot_x      (shot_x),
    .shot_y      (shot_y)
  );

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Damage strobes are checked against the scoreboard at the falling edge.
  always @(negedge clk) begin
    if (new_damage === 1'b1) begin
      logic [21:0] e;
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $error("FAIL unexpected_damage observed=(%0d,%0d) expected=none", damage_x, damage_y);
      end else begin
        e = sb_q.pop_front();
        assert ({damage_x, damage_y} === e) else begin
          n_err++;
          $error("FAIL damage_xy observed=(%0d,%0d) expected=(%0d,%0d)",
                 damage_x, damage_y, e[21:11], e[10:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic launch(input logic [10:0] x);
    fire_x = x;
    fire   = 1'b1;
    step();
    fire   = 1'b0;
  endtask

  // Presents (x,y) on the raster, then its barrier flag one cycle later.
  task automatic pix(input logic [10:0] x, input logic [10:0] y, input logic b, input logic t);
    xCoord = x; yCoord = y; is_barrier = 1'b0;
    step();
    xCoord = '0; yCoord = '0; is_barrier = b; frame_tick = t;
    step();
    is_barrier = 1'b0; frame_tick = 1'b0;
  endtask

  initial begin
    int exp_y;
    rst = 1'b1; restart = 1'b0; fire = 1'b0; frame_tick = 1'b0; is_barrier = 1'b0;
    fire_x = '0; xCoord = '0; yCoord = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_shot_active", {10'd0, shot_active}, 11'd0);
    chk("rst_new_damage", {10'd0, new_damage}, 11'd0);
    chk("rst_shot_y", shot_y, 11'd0);
    chk("rst_damage_x", damage_x, 11'd0);

    // Free flight, no barrier: climbs to row 8 then retires.
    launch(11'd100);
    chk("launch_active", {10'd0, shot_active}, 11'd1);
    chk("launch_x", shot_x, 11'd100);
    chk("launch_y", shot_y, 11'd440);
    exp_y = 440;
    for (int i = 0; i < 108; i++) begin
      tick();
      exp_y -= 4;
      chk("fly_y", shot_y, 11'(exp_y));
      chk("fly_active", {10'd0, shot_active}, 11'd1);
    end
    tick();
    chk("retire_active", {10'd0, shot_active}, 11'd0);
    step();

    // Hit over several rows, first in raster order is reported.
    launch(11'd120);
    for (int i = 0; i < 12; i++) tick();
    chk("hit1_y", shot_y, 11'd392);
    launch(11'd300);
    chk("refire_x", shot_x, 11'd120);
    chk("refire_y", shot_y, 11'd392);
    sb_q.push_back({11'd120, 11'd56});
    pix(11'd120, 11'd396, 1'b1, 1'b0);
    pix(11'd120, 11'd397, 1'b1, 1'b0);
    pix(11'd120, 11'd398, 1'b1, 1'b0);
    pix(11'd120, 11'd399, 1'b1, 1'b0);
    chk("hit1_no_early", {10'd0, new_damage}, 11'd0);
    tick();
    chk("hit1_strobe", {10'd0, new_damage}, 11'd1);
    launch(11'd200);
    chk("emit_fire_ignored_y", shot_y, 11'd392);
    chk("post_emit_active", {10'd0, shot_active}, 11'd0);
    chk("post_emit_strobe", {10'd0, new_damage}, 11'd0);
    chk("hold_damage_x", damage_x, 11'd120);
    launch(11'd120);
    chk("relaunch_y", shot_y, 11'd440);
    chk("relaunch_active", {10'd0, shot_active}, 11'd1);

    // Hit arriving with the frame_tick itself.
    for (int i = 0; i < 12; i++) tick();
    sb_q.push_back({11'd120, 11'd56});
    pix(11'd120, 11'd396, 1'b1, 1'b1);
    chk("same_tick_strobe", {10'd0, new_damage}, 11'd1);
    step();
    chk("same_tick_active", {10'd0, shot_active}, 11'd0);

    // Off-column and off-range pixels never register.
    launch(11'd120);
    for (int i = 0; i < 12; i++) tick();
    pix(11'd121, 11'd396, 1'b1, 1'b0);
    pix(11'd120, 11'd400, 1'b1, 1'b0);
    pix(11'd120, 11'd391, 1'b1, 1'b0);
    tick();
    chk("miss_strobe", {10'd0, new_damage}, 11'd0);
    chk("miss_y", shot_y, 11'd388);
    chk("miss_active", {10'd0, shot_active}, 11'd1);

    // Restart on the closing tick cancels the pending damage.
    pix(11'd120, 11'd390, 1'b1, 1'b0);
    restart = 1'b1; frame_tick = 1'b1;
    step();
    restart = 1'b0; frame_tick = 1'b0;
    chk("restart_strobe", {10'd0, new_damage}, 11'd0);
    chk("restart_active", {10'd0, shot_active}, 11'd0);
    chk("restart_shot_x", shot_x, 11'd0);
    chk("restart_shot_y", shot_y, 11'd0);
    chk("restart_damage_x", damage_x, 11'd0);
    chk("restart_damage_y", damage_y, 11'd0);
    step(); step();
    chk("restart_no_late_strobe", {10'd0, new_damage}, 11'd0);

    chk("scoreboard_drained", 11'(sb_q.size()), 11'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
